// File: rtl/dmem_cache_resp_pkg.sv
// rtl/dmem_cache_resp_pkg.sv - shared encodings, FSM states and width helpers for dmem_cache_resp
//
// Purpose : request-bit positions, FSM state type, and derived address-field widths.
// Contents: MEM_LOAD / MEM_STORE bit indices, state_t {IDLE, FILL},
//           word_w() / idx_w() / tag_w() constant functions.
package dmem_cache_resp_pkg;

    localparam int MEM_LOAD  = 0;
    localparam int MEM_STORE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Word-index width into the backing array.
    function automatic int word_w(input int mem_words);
        return $clog2(mem_words);
    endfunction

    // Cache index width (LINES is a power of two, at least 2).
    function automatic int idx_w(input int lines);
        return $clog2(lines);
    endfunction

    // Tag is whatever word-index bits remain above the line index.
    function automatic int tag_w(input int mem_words, input int lines);
        return $clog2(mem_words) - $clog2(lines);
    endfunction

endpackage

// File: rtl/dmem_cache_resp_dc_line_array.sv
// rtl/dmem_cache_resp_dc_line_array.sv - valid/tag/data line storage with combinational hit compare
//
// Purpose : one-word cache lines for dmem_cache_resp.
// Ports   : clk, rst_n        - clock, async active-low reset (clears valid bits only)
//           i_rd_idx/i_rd_tag - read-port lookup; o_hit / o_rd_data combinational
//           i_we, i_wr_idx, i_wr_tag, i_wr_data - write port; a write also sets valid
module dc_line_array #(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [TAG_W-1:0] i_rd_tag,
    output logic             o_hit,
    output logic [31:0]      o_rd_data,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data
);

    logic [LINES-1:0] r_valid;
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [31:0]      r_data [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_idx];

endmodule

// File: rtl/dmem_cache_resp.sv
// rtl/dmem_cache_resp.sv - direct-mapped write-through data-memory responder with stall on load miss
//
// Purpose : serves MEM-stage loads/stores; load hits and stores finish in the request
//           cycle, load misses hold BUSY for MISS_LAT+1 cycles while the line refills.
// Ports   : clk, rst (async active-low)
//           MEM[1:0] (bit0 load, bit1 store), Addr, Wdata  - request
//           Rdata, BUSY                                    - response / stall
//           hit_cnt, miss_cnt                              - saturating load hit/miss counts
module dmem_cache_resp
    import dmem_cache_resp_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LINES     = 16,
    parameter int MISS_LAT  = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       MEM,
    input  logic [31:0]      Addr,
    input  logic [31:0]      Wdata,
    output logic [31:0]      Rdata,
    output logic             BUSY,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int WORD_W = word_w(MEM_WORDS);
    localparam int IDX_W  = idx_w(LINES);
    localparam int TAG_W  = tag_w(MEM_WORDS, LINES);
    localparam int CNT_LW = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_LW-1:0] r_cnt;
    logic [WORD_W-1:0] r_word;
    logic [31:0]       r_mem [MEM_WORDS];

    logic [WORD_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_load;
    logic              w_store;
    logic              w_hit;
    logic [31:0]       w_line_data;
    logic              w_load_hit;
    logic              w_load_miss;
    logic              w_store_en;
    logic              w_fill_done;
    logic              w_line_we;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [TAG_W-1:0]  w_wr_tag;
    logic [31:0]       w_wr_data;
    logic              w_unused_addr;

    assign w_word        = Addr[WORD_W+1:2];
    assign w_idx         = w_word[IDX_W-1:0];
    assign w_tag         = w_word[WORD_W-1:IDX_W];
    assign w_unused_addr = ^{Addr[31:WORD_W+2], Addr[1:0]};

    // MEM=11 is a store only; the load bit is ignored in that case.
    assign w_store = MEM[MEM_STORE];
    assign w_load  = MEM[MEM_LOAD] && !MEM[MEM_STORE];

    dc_line_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_lines (
        .clk       (clk),
        .rst_n     (rst),
        .i_rd_idx  (w_idx),
        .i_rd_tag  (w_tag),
        .o_hit     (w_hit),
        .o_rd_data (w_line_data),
        .i_we      (w_line_we),
        .i_wr_idx  (w_wr_idx),
        .i_wr_tag  (w_wr_tag),
        .i_wr_data (w_wr_data)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_load_miss) w_state_nxt = FILL;
            FILL:    if (r_cnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. Everything is forced quiet while reset is asserted, so a
    // load held across reset does not show up as a combinational miss.
    always_comb begin
        BUSY        = 1'b0;
        Rdata       = '0;
        w_load_hit  = 1'b0;
        w_load_miss = 1'b0;
        w_store_en  = 1'b0;
        w_fill_done = 1'b0;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    if (w_store) begin
                        w_store_en = 1'b1;
                    end else if (w_load) begin
                        if (w_hit) begin
                            w_load_hit = 1'b1;
                            Rdata      = w_line_data;
                        end else begin
                            w_load_miss = 1'b1;
                            BUSY        = 1'b1;
                        end
                    end
                end
                FILL: begin
                    BUSY        = 1'b1;
                    w_fill_done = (r_cnt == '0);
                end
                default: ;
            endcase
        end
    end

    // Line write port: refill completion has priority; otherwise a store that
    // hits keeps the line coherent with the write-through backing array.
    assign w_line_we = w_fill_done || (w_store_en && w_hit);
    assign w_wr_idx  = w_fill_done ? r_word[IDX_W-1:0]      : w_idx;
    assign w_wr_tag  = w_fill_done ? r_word[WORD_W-1:IDX_W] : w_tag;
    assign w_wr_data = w_fill_done ? r_mem[r_word]          : Wdata;

    always_ff @(posedge clk) begin
        if (w_store_en) begin
            r_mem[w_word] <= Wdata;
        end
    end

    // Refill countdown and latched miss address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (w_load_miss) begin
            r_cnt  <= CNT_LW'(MISS_LAT - 1);
            r_word <= w_word;
        end else if (r_state == FILL && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (w_load_hit && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (w_load_miss && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_cache_resp.sv
// tb/tb_dmem_cache_resp.sv - scoreboard bench for dmem_cache_resp
module tb_dmem_cache_resp;

    localparam int MISS_LAT = 4;
    localparam int CNT_W    = 2;
    localparam int MISS_BUSY = MISS_LAT + 1;

    logic             clk;
    logic             rst;
    logic [1:0]       MEM;
    logic [31:0]      Addr;
    logic [31:0]      Wdata;
    logic [31:0]      Rdata;
    logic             BUSY;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];

    dmem_cache_resp #(
        .MEM_WORDS (1024),
        .LINES     (16),
        .MISS_LAT  (MISS_LAT),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MEM      (MEM),
        .Addr     (Addr),
        .Wdata    (Wdata),
        .Rdata    (Rdata),
        .BUSY     (BUSY),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: completed load responses are popped from the scoreboard;
    // in every other cycle Rdata must read zero.
    always @(negedge clk) begin
        if (rst && MEM == 2'b01 && !BUSY) begin
            if (sb_q.size() == 0) begin
                check("unexpected_load_resp", 32'h1, 32'h0);
            end else begin
                check("load_rdata", Rdata, sb_q.pop_front());
            end
        end else begin
            check("rdata_zero", Rdata, 32'h0);
        end
    end

    task automatic chk_cnt(input string name, input int h, input int m);
        check({name, "_hit_cnt"},  32'(hit_cnt),  32'(h));
        check({name, "_miss_cnt"}, 32'(miss_cnt), 32'(m));
    endtask

    task automatic do_store(input logic [1:0] mem, input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        MEM = mem; Addr = addr; Wdata = data;
        @(negedge clk);
        check("store_busy", 32'(BUSY), 32'h0);
        @(posedge clk); #1;
        MEM = 2'b00;
    endtask

    task automatic do_load(input string name, input logic [31:0] addr,
                           input logic [31:0] exp, input int exp_busy);
        int n;
        bit done;
        @(posedge clk); #1;
        MEM = 2'b01; Addr = addr;
        sb_q.push_back(exp);
        n = 0;
        done = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (BUSY) n++;
            else done = 1;
        end
        if (!done) begin
            check({name, "_timeout"}, 32'h1, 32'h0);
            void'(sb_q.pop_back());
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        @(posedge clk); #1;
        MEM = 2'b00;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        MEM = 2'b00;
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(BUSY), 32'h0);
        check("rst_rdata", Rdata, 32'h0);
        chk_cnt("rst", 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        int n;
        rst = 1'b0; MEM = 2'b00; Addr = '0; Wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("init_busy", 32'(BUSY), 32'h0);
        chk_cnt("init", 0, 0);
        rst = 1'b1;

        // Cold miss after a write-through store.
        do_store(2'b10, 32'h40, 32'hDEADBEEF);
        do_load("cold_miss", 32'h40, 32'hDEADBEEF, MISS_BUSY);
        chk_cnt("cold_miss", 1, 1);

        // Store hit updates the line; next load hits.
        do_store(2'b10, 32'h40, 32'h12345678);
        do_load("store_hit_load", 32'h40, 32'h12345678, 0);
        chk_cnt("store_hit_load", 2, 1);

        // Store miss does not allocate; conflict eviction on idx 0.
        do_store(2'b10, 32'h80, 32'hCAFEF00D);
        do_load("conflict_a", 32'h80, 32'hCAFEF00D, MISS_BUSY);
        chk_cnt("conflict_a", 3, 2);
        do_load("conflict_b", 32'h40, 32'h12345678, MISS_BUSY);
        chk_cnt("conflict_b", 3, 3);

        // Saturation at 2'b11 for both counters.
        do_load("sat_hit1", 32'h40, 32'h12345678, 0);
        do_load("sat_hit2", 32'h40, 32'h12345678, 0);
        do_load("sat_miss", 32'h80, 32'hCAFEF00D, MISS_BUSY);
        chk_cnt("saturate", 3, 3);

        // Reset mid-run: counters clear, lines invalidate.
        pulse_reset();

        // MEM=11 is store only: no response, no counter change, backing written.
        do_store(2'b11, 32'h44, 32'h00000005);
        chk_cnt("mem11", 0, 0);
        do_load("mem11_readback", 32'h44, 32'h00000005, MISS_BUSY);
        do_load("post_reset_miss", 32'h80, 32'hCAFEF00D, MISS_BUSY);
        chk_cnt("post_reset", 2, 2);

        // Reset in the 3rd BUSY cycle of a miss.
        @(posedge clk); #1;
        MEM = 2'b01; Addr = 32'h40;
        n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            @(negedge clk);
            if (BUSY) n++;
        end
        check("fill_abort_reached", 32'(n), 32'd3);
        #1;
        rst = 1'b0;
        #1;
        check("fill_abort_busy", 32'(BUSY), 32'h0);
        check("fill_abort_rdata", Rdata, 32'h0);
        chk_cnt("fill_abort", 0, 0);
        MEM = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        do_load("after_abort", 32'h40, 32'h12345678, MISS_BUSY);
        chk_cnt("after_abort", 1, 1);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
